demux_16_pipe: RTL and testbench

- Registered 1-to-16 demultiplexer with valid/ready handshake on both sides; it is the write-side counterpart to the 16:1 read-select mux.
- Accepts one word plus a 4-bit destination and presents it to exactly one of 16 sinks, or to all 16 when broadcast is requested.
- Holds the word until every targeted sink has accepted it.
- Sits between a single producer (control/bus master) and 16 register-slot or peripheral consumers.

---
 rtl/demux_pkg.sv | 13 +
 rtl/dec_4to16.sv | 15 +
 rtl/demux_16_pipe.sv | 71 +++++++
 tb/tb_demux_16_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-16 write-side demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_PORTS = 16;
    localparam int unsigned SEL_W     = 4;

    typedef logic [NUM_PORTS-1:0] port_mask_t;
    typedef logic [SEL_W-1:0]     port_sel_t;

    // Mask used when a word is broadcast to every sink.
    localparam port_mask_t ALL_PORTS = '1;

endpackage

// File: rtl/dec_4to16.sv
// Combinational 4-bit select to 16-bit one-hot decoder.
module dec_4to16
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_PORTS-1:0] onehot
);

    // Exactly one bit set, at the position named by sel.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/demux_16_pipe.sv
// Registered 1-to-16 demultiplexer with valid/ready on both sides. A word is held
// until every targeted sink (one, or all sixteen on broadcast) has accepted it.
// The pending mask doubles as the state: zero means empty, non-zero means holding.
module demux_16_pipe
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_bcast,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 busy
);

    logic [WIDTH-1:0] hold_q, hold_d;
    port_mask_t       pend_q, pend_d;
    port_mask_t       sel_mask;
    port_mask_t       acc;
    port_mask_t       pend_next;
    logic             xfer;

    dec_4to16 u_dec (
        .sel    (in_sel),
        .onehot (sel_mask)
    );

    // Drain accepted bits; ready once nothing would remain pending after this
    // cycle, so a new word can replace the last accepted one without a bubble.
    always_comb begin
        acc       = pend_q & out_ready;
        pend_next = pend_q & ~acc;
        in_ready  = (pend_next == '0);
        xfer      = in_valid & in_ready;
    end

    // Next-state: load on a transfer, otherwise keep draining the current word.
    always_comb begin
        pend_d = pend_next;
        hold_d = hold_q;
        if (xfer) begin
            hold_d = in_data;
            pend_d = in_bcast ? ALL_PORTS : sel_mask;
        end
    end

    // State registers with synchronous reset; pending words are dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            hold_q <= '0;
        end else begin
            pend_q <= pend_d;
            hold_q <= hold_d;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        out_valid = pend_q;
        out_data  = hold_q;
        busy      = |pend_q;
    end

endmodule

// File: tb/tb_demux_16_pipe.sv
// Self-checking bench for demux_16_pipe: directed scenarios plus a randomized run
// against a per-sink pending-list model.
module tb_demux_16_pipe;

    localparam int unsigned WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic [3:0]        in_sel = '0;
    logic              in_bcast = 1'b0;
    logic [15:0]       out_valid;
    logic [15:0]       out_ready = '0;
    logic [WIDTH-1:0]  out_data;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: which sinks still owe an acceptance, and the word they see.
    bit               m_pend [16];
    logic [WIDTH-1:0] m_data = '0;

    demux_16_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Ready if every sink still owed the word takes it this cycle.
    function automatic bit model_ready();
        for (int i = 0; i < 16; i++)
            if (m_pend[i] && !out_ready[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = m_pend[i];
        return m;
    endfunction

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        bit rdy;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
            m_data = '0;
        end else begin
            rdy = model_ready();
            for (int i = 0; i < 16; i++)
                if (m_pend[i] && out_ready[i]) m_pend[i] = 1'b0;
            if (in_valid && rdy) begin
                m_data = in_data;
                for (int i = 0; i < 16; i++)
                    m_pend[i] = in_bcast || (i == int'(in_sel));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 16'h0000) $display("FAIL reset_out_valid got %h want 0000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_unicast_stall();
        in_data  = 32'hDEADBEEF;
        in_sel   = 4'd5;
        in_valid = 1'b1;
        out_ready = '0;
        tick();
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_sel   = 4'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (out_valid !== 16'h0020) $display("FAIL uni_stall_valid c%0d got %h want 0020", c, out_valid);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 32'hDEADBEEF) $display("FAIL uni_stall_data c%0d got %h want deadbeef", c, out_data);
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL uni_stall_ready c%0d got %b want 0", c, in_ready);
            else pass_cnt++;
            tick();
        end
        out_ready = 16'h0020;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL uni_accept_ready got %b want 1", in_ready);
        else pass_cnt++;
        tick();
        out_ready = '0;
        #1;
        total_cnt++;
        if (out_valid !== 16'h0000) $display("FAIL uni_cleared got %h want 0000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL uni_busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] sels [4];
        sels[0] = 4'd0; sels[1] = 4'd15; sels[2] = 4'd7; sels[3] = 4'd7;
        out_ready = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k + 1);
            in_sel   = sels[k];
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready w%0d got %b want 1", k, in_ready);
            else pass_cnt++;
            tick();
            #1;
            total_cnt++;
            if (out_valid !== (16'h1 << sels[k]))
                $display("FAIL b2b_valid w%0d got %h want %h", k, out_valid, 16'h1 << sels[k]);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 32'(k + 1)) $display("FAIL b2b_data w%0d got %h want %h", k, out_data, k + 1);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        out_ready = '0;
        total_cnt++;
        if (out_valid !== 16'h0000) $display("FAIL b2b_drained got %h want 0000", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_bcast_staggered();
        logic [15:0] groups [3];
        logic [15:0] after  [3];
        groups[0] = 16'h00FF; groups[1] = 16'h7F00; groups[2] = 16'h8000;
        after[0]  = 16'hFF00; after[1]  = 16'h8000; after[2]  = 16'h0000;
        out_ready = '0;
        in_bcast  = 1'b1;
        in_sel    = 4'd2;
        in_data   = 32'h12345678;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        in_data  = 32'hFFFF_0000;
        #1;
        total_cnt++;
        if (out_valid !== 16'hFFFF) $display("FAIL bcast_loaded got %h want ffff", out_valid);
        else pass_cnt++;
        for (int g = 0; g < 3; g++) begin
            out_ready = groups[g];
            #1;
            total_cnt++;
            if (in_ready !== (g == 2)) $display("FAIL bcast_ready g%0d got %b want %0d", g, in_ready, g == 2);
            else pass_cnt++;
            tick();
            #1;
            total_cnt++;
            if (out_valid !== after[g]) $display("FAIL bcast_step g%0d got %h want %h", g, out_valid, after[g]);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 32'h12345678) $display("FAIL bcast_data g%0d got %h want 12345678", g, out_data);
            else pass_cnt++;
        end
        out_ready = '0;
    endtask

    task automatic test_spurious_reset();
        in_data  = $urandom;
        in_sel   = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 16'hFFF7;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL spur_ready c%0d got %b want 0", c, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 16'h0008) $display("FAIL spur_valid c%0d got %h want 0008", c, out_valid);
            else pass_cnt++;
        end
        out_ready = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 16'h0000) $display("FAIL midrst_valid got %h want 0000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0) $display("FAIL midrst_data got %h want 0", out_data);
        else pass_cnt++;
    endtask

    task automatic test_ignored_inputs();
        out_ready = '0;
        in_data   = 32'hA5A5_0001;
        in_sel    = 4'd9;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            in_sel  = 4'($urandom_range(0, 15));
            tick();
            total_cnt++;
            if (out_valid !== 16'h0200) $display("FAIL ign_valid c%0d got %h want 0200", c, out_valid);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 32'hA5A5_0001) $display("FAIL ign_data c%0d got %h want a5a50001", c, out_data);
            else pass_cnt++;
        end
        out_ready = 16'hFFFF;
        in_bcast  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_sel   = 4'($urandom_range(0, 15));
            in_data  = $urandom;
            tick();
            total_cnt++;
            if (out_valid !== 16'hFFFF) $display("FAIL ign_bcast c%0d sel %0d got %h want ffff", c, in_sel, out_valid);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        in_bcast = 1'b0;
        tick();
        out_ready = '0;
    endtask

    task automatic test_random();
        bit stalled = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
                in_sel   = 4'($urandom_range(0, 15));
                in_bcast = ($urandom_range(0, 7) == 0);
            end
            out_ready = 16'($urandom) | 16'($urandom);
            #1;
            total_cnt++;
            if (in_ready !== model_ready()) $display("FAIL rnd_ready c%0d got %b want %b", c, in_ready, model_ready());
            else pass_cnt++;
            stalled = in_valid && !model_ready() && !reset;
            tick();
            #1;
            total_cnt++;
            if (out_valid !== model_mask()) $display("FAIL rnd_valid c%0d got %h want %h", c, out_valid, model_mask());
            else pass_cnt++;
            total_cnt++;
            if (out_data !== m_data) $display("FAIL rnd_data c%0d got %h want %h", c, out_data, m_data);
            else pass_cnt++;
            total_cnt++;
            if (busy !== (model_mask() != 16'h0)) $display("FAIL rnd_busy c%0d got %b want %b", c, busy, model_mask() != 16'h0);
            else pass_cnt++;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        out_ready = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_unicast_stall();
        test_back_to_back();
        test_bcast_staggered();
        test_spurious_reset();
        test_ignored_inputs();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
